// File: rtl/pwm_fade_ctrl_if.sv
// Target-request channel of the PWM fade controller: a valid/ready handshake
// that carries the target duty together with the step size and step rate.
interface pwm_fade_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int RATE_W = 16
);
  logic              tgt_valid_i;
  logic              tgt_ready_o;
  logic [WIDTH-1:0]  tgt_duty_i;
  logic [WIDTH-1:0]  step_i;
  logic [RATE_W-1:0] rate_i;

  modport master (
    output tgt_valid_i, tgt_duty_i, step_i, rate_i,
    input  tgt_ready_o
  );

  modport slave (
    input  tgt_valid_i, tgt_duty_i, step_i, rate_i,
    output tgt_ready_o
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for the pwm block: ramps duty_o toward an accepted target,
// one step every rate PWM periods, updating only at PWM period boundaries.
module pwm_fade_ctrl #(
  parameter int WIDTH  = 8,
  parameter int RATE_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pwm_fade_ctrl_if.slave   tgt,
  input  logic             abort_i,
  output logic [WIDTH-1:0] duty_o,
  output logic             period_start_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  per_cnt_reg;
  logic [WIDTH-1:0]  duty_reg, duty_next;
  logic [WIDTH-1:0]  tgt_reg, tgt_next;
  logic [WIDTH-1:0]  step_reg, step_next;
  logic [RATE_W-1:0] rate_reg, rate_next;
  logic [RATE_W-1:0] rate_cnt_reg, rate_cnt_next;
  logic              dir_up_reg, dir_up_next;
  logic              done_reg, done_next;

  logic              period_end;
  logic [WIDTH-1:0]  step_eff;
  logic [RATE_W-1:0] rate_eff;
  logic [WIDTH:0]    up_sum;
  logic [WIDTH-1:0]  dn_diff;
  logic [WIDTH-1:0]  stepped_duty;

  assign period_end     = (per_cnt_reg == {WIDTH{1'b1}});
  assign period_start_o = (per_cnt_reg == '0);
  assign tgt.tgt_ready_o = (state_reg == IDLE);
  assign busy_o         = (state_reg == RAMP);
  assign duty_o         = duty_reg;
  assign done_o         = done_reg;

  assign step_eff = (tgt.step_i == '0) ? WIDTH'(1) : tgt.step_i;
  assign rate_eff = (tgt.rate_i == '0) ? RATE_W'(1) : tgt.rate_i;

  // One extra bit on the way up so a large step saturates at the target instead of wrapping.
  assign up_sum  = {1'b0, duty_reg} + {1'b0, step_reg};
  assign dn_diff = duty_reg - step_reg;

  always_comb begin
    stepped_duty = tgt_reg;
    if (dir_up_reg) begin
      if (up_sum <= {1'b0, tgt_reg}) stepped_duty = up_sum[WIDTH-1:0];
    end else begin
      if ((duty_reg >= step_reg) && (dn_diff > tgt_reg)) stepped_duty = dn_diff;
    end
  end

  always_comb begin
    state_next    = state_reg;
    duty_next     = duty_reg;
    tgt_next      = tgt_reg;
    step_next     = step_reg;
    rate_next     = rate_reg;
    rate_cnt_next = rate_cnt_reg;
    dir_up_next   = dir_up_reg;
    done_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tgt.tgt_valid_i) begin
          tgt_next  = tgt.tgt_duty_i;
          step_next = step_eff;
          rate_next = rate_eff;
          if (tgt.tgt_duty_i == duty_reg) begin
            done_next = 1'b1;
          end else begin
            state_next    = RAMP;
            dir_up_next   = (tgt.tgt_duty_i > duty_reg);
            rate_cnt_next = rate_eff - RATE_W'(1);
          end
        end
      end
      RAMP: begin
        // Abort wins over a step falling on the same period end.
        if (abort_i) begin
          state_next = IDLE;
        end else if (period_end) begin
          if (rate_cnt_reg != '0) begin
            rate_cnt_next = rate_cnt_reg - RATE_W'(1);
          end else begin
            duty_next     = stepped_duty;
            rate_cnt_next = rate_reg - RATE_W'(1);
            if (stepped_duty == tgt_reg) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      per_cnt_reg  <= '0;
      duty_reg     <= '0;
      tgt_reg      <= '0;
      step_reg     <= WIDTH'(1);
      rate_reg     <= RATE_W'(1);
      rate_cnt_reg <= '0;
      dir_up_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      per_cnt_reg  <= per_cnt_reg + WIDTH'(1);
      duty_reg     <= duty_next;
      tgt_reg      <= tgt_next;
      step_reg     <= step_next;
      rate_reg     <= rate_next;
      rate_cnt_reg <= rate_cnt_next;
      dir_up_reg   <= dir_up_next;
      done_reg     <= done_next;
    end
  end

endmodule
